// File: rtl/product_accumulator.sv
// product_accumulator
// Sums unsigned products from an upstream multiplier into frames of len_i
// products and dumps each frame sum once. The sum saturates at full scale,
// and a sticky flag records that saturation happened during the frame.
//
// Ports
//   clk        in   clock, rising-edge
//   rst_n      in   async active-low reset
//   sync_i     in   abort the current frame; restart accumulation
//   en_i       in   data_i holds a valid product this cycle
//   data_i     in   [DATA_WIDTH-1:0] unsigned product
//   len_i      in   [LEN_WIDTH-1:0] products per frame (0 is taken as 1)
//   data_o     out  [ACC_WIDTH-1:0] registered frame sum, held between dumps
//   valid_o    out  one-cycle pulse when data_o has been updated
//   overflow_o out  frame sum saturated; qualified by valid_o
module product_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ACC_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  output logic                  overflow_o
);

  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  logic [ACC_WIDTH-1:0] sum_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 sticky_q;

  logic                 first;
  logic [ACC_WIDTH-1:0] base_sum;
  logic [LEN_WIDTH-1:0] base_cnt;
  logic                 base_sticky;
  logic [LEN_WIDTH-1:0] eff_len;
  logic [SUM_W-1:0]     add_full;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] new_sum;
  logic [LEN_WIDTH-1:0] new_cnt;
  logic                 new_sticky;
  logic                 last;

  // A frame starts whenever the counter is empty (after reset or a dump) or
  // when sync_i discards the old frame. In that case the old sum, count and
  // flag are ignored and the length comes straight from len_i.
  always_comb begin
    first       = sync_i || (cnt_q == '0);
    base_sum    = first ? '0 : sum_q;
    base_cnt    = first ? '0 : cnt_q;
    base_sticky = first ? 1'b0 : sticky_q;
    if (first)
      eff_len = (len_i == '0) ? LEN_WIDTH'(1) : len_i;
    else
      eff_len = len_q;
    add_full   = SUM_W'(base_sum) + SUM_W'(data_i);
    add_ovf    = add_full[ACC_WIDTH];
    new_sum    = add_ovf ? ACC_MAX : add_full[ACC_WIDTH-1:0];
    new_sticky = base_sticky | add_ovf;
    // cnt_q stays below eff_len, so this increment cannot wrap.
    new_cnt    = base_cnt + LEN_WIDTH'(1);
    last       = en_i && (new_cnt == eff_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      sticky_q   <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (en_i) begin
        if (first)
          len_q <= eff_len;
        if (last) begin
          data_o     <= new_sum;
          overflow_o <= new_sticky;
          valid_o    <= 1'b1;
          sum_q      <= '0;
          cnt_q      <= '0;
          sticky_q   <= 1'b0;
        end else begin
          sum_q    <= new_sum;
          cnt_q    <= new_cnt;
          sticky_q <= new_sticky;
        end
      end else if (sync_i) begin
        sum_q    <= '0;
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_i = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [7:0]  len_i = '0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        overflow_o;
  logic [15:0] data16_o;
  logic        valid16_o;
  logic        overflow16_o;

  int vec_cnt = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .sync_i(sync_i), .en_i(en_i),
    .data_i(data_i), .len_i(len_i),
    .data_o(data_o), .valid_o(valid_o), .overflow_o(overflow_o)
  );

  product_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .sync_i(sync_i), .en_i(en_i),
    .data_i(data_i), .len_i(len_i),
    .data_o(data16_o), .valid_o(valid16_o), .overflow_o(overflow16_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the capturing edge.
  task automatic step(input logic s, input logic e, input logic [15:0] d, input logic [7:0] l);
    sync_i = s; en_i = e; data_i = d; len_i = l;
    @(posedge clk);
    #1;
    sync_i = 1'b0; en_i = 1'b0;
  endtask

  task automatic clear_frame();
    step(1'b1, 1'b0, 16'd0, 8'd0);
  endtask

  initial begin
    #3;
    chk("rst_data", data_o, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_ovf", {31'd0, overflow_o}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // four consecutive products
    step(0, 1, 16'd748, 8'd4);  chk("f1_v0", {31'd0, valid_o}, 0);
    step(0, 1, 16'd306, 8'd4);  chk("f1_v1", {31'd0, valid_o}, 0);
    step(0, 1, 16'd81,  8'd4);  chk("f1_v2", {31'd0, valid_o}, 0);
    step(0, 1, 16'd891, 8'd4);
    chk("f1_valid", {31'd0, valid_o}, 1);
    chk("f1_data", data_o, 2026);
    chk("f1_ovf", {31'd0, overflow_o}, 0);
    step(0, 0, 16'd0, 8'd4);
    chk("f1_pulse_end", {31'd0, valid_o}, 0);
    chk("f1_hold", data_o, 2026);

    // gaps of two idle cycles, len_i changed after the first product
    step(0, 1, 16'd748, 8'd4);
    step(0, 0, 16'd0, 8'd2); step(0, 0, 16'd0, 8'd2);
    step(0, 1, 16'd306, 8'd2);
    step(0, 0, 16'd0, 8'd2); step(0, 0, 16'd0, 8'd2);
    step(0, 1, 16'd81, 8'd2);
    chk("gap_no_early", {31'd0, valid_o}, 0);
    step(0, 0, 16'd0, 8'd2); step(0, 0, 16'd0, 8'd2);
    step(0, 1, 16'd891, 8'd2);
    chk("gap_valid", {31'd0, valid_o}, 1);
    chk("gap_data", data_o, 2026);

    // back-to-back frames of two
    step(0, 1, 16'd9801, 8'd2);
    step(0, 1, 16'd9801, 8'd2);
    chk("b2b_v1", {31'd0, valid_o}, 1);
    chk("b2b_d1", data_o, 19602);
    step(0, 1, 16'd81, 8'd2);
    chk("b2b_mid", {31'd0, valid_o}, 0);
    step(0, 1, 16'd81, 8'd2);
    chk("b2b_v2", {31'd0, valid_o}, 1);
    chk("b2b_d2", data_o, 162);

    // saturation on the 16-bit accumulator instance
    clear_frame();
    step(0, 1, 16'd65000, 8'd2);
    step(0, 1, 16'd1000, 8'd2);
    chk("sat_valid", {31'd0, valid16_o}, 1);
    chk("sat_data", {16'd0, data16_o}, 65535);
    chk("sat_ovf", {31'd0, overflow16_o}, 1);
    step(0, 1, 16'd1, 8'd2);
    step(0, 1, 16'd1, 8'd2);
    chk("sat_next_data", {16'd0, data16_o}, 2);
    chk("sat_next_ovf", {31'd0, overflow16_o}, 0);

    // length 0 behaves as 1
    clear_frame();
    step(0, 1, 16'd5, 8'd0);
    chk("len0_valid", {31'd0, valid_o}, 1);
    chk("len0_data", data_o, 5);

    // sync with en starts a new frame mid-frame
    step(0, 1, 16'd748, 8'd3);
    step(0, 1, 16'd306, 8'd3);
    step(1, 1, 16'd81, 8'd3);
    chk("sync_no_pulse", {31'd0, valid_o}, 0);
    chk("sync_hold", data_o, 5);
    step(0, 1, 16'd891, 8'd3);
    chk("sync_mid", {31'd0, valid_o}, 0);
    step(0, 1, 16'd9801, 8'd3);
    chk("sync_valid", {31'd0, valid_o}, 1);
    chk("sync_data", data_o, 10773);

    // sync coinciding with the Nth product wins
    step(0, 1, 16'd10, 8'd2);
    step(1, 1, 16'd20, 8'd2);
    chk("syncN_no_pulse", {31'd0, valid_o}, 0);
    step(0, 1, 16'd30, 8'd2);
    chk("syncN_data", data_o, 50);

    // sync without en discards, no pulse
    step(0, 1, 16'd7, 8'd2);
    step(1, 0, 16'd0, 8'd2);
    chk("sync_only_pulse", {31'd0, valid_o}, 0);
    step(0, 1, 16'd3, 8'd2);
    step(0, 1, 16'd4, 8'd2);
    chk("sync_only_data", data_o, 7);

    // async reset mid-frame
    step(0, 1, 16'd748, 8'd4); step(0, 1, 16'd306, 8'd4);
    step(0, 1, 16'd81, 8'd4);  step(0, 1, 16'd891, 8'd4);
    chk("pre_rst_data", data_o, 2026);
    step(0, 1, 16'd100, 8'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", data_o, 0);
    chk("arst_valid", {31'd0, valid_o}, 0);
    chk("arst_ovf", {31'd0, overflow_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 16'd81, 8'd1);
    chk("post_rst_valid", {31'd0, valid_o}, 1);
    chk("post_rst_data", data_o, 81);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
